// File: rtl/pipeline_pkg.sv
// Shared pipeline helpers: width functions for the hold queue and the
// per-cycle update classification used by its control logic.
package pipeline_pkg;

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int hold_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries, never less than one.
    function automatic int hold_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Mutually exclusive state update for one cycle.
    typedef enum logic [2:0] {
        UPD_IDLE   = 3'd0,
        UPD_BYPASS = 3'd1,
        UPD_BOTH   = 3'd2,
        UPD_PUSH   = 3'd3,
        UPD_POP    = 3'd4
    } upd_e;

endpackage

// File: rtl/hold_queue_if.sv
// Upstream/downstream port bundle of the hold queue. The queue uses the
// slave modport; the driving environment uses the master modport.
interface hold_queue_if
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    logic [WIDTH-1:0]                   data_in;
    logic                               input_valid;
    logic                               ready_out;
    logic [WIDTH-1:0]                   data_out;
    logic                               valid_out;
    logic                               stall;
    logic                               flush;
    logic [hold_count_width(DEPTH)-1:0] count;
    logic                               overflow;

    modport master (
        output data_in, input_valid, stall, flush,
        input  ready_out, data_out, valid_out, count, overflow
    );

    modport slave (
        input  data_in, input_valid, stall, flush,
        output ready_out, data_out, valid_out, count, overflow
    );
endinterface

// File: rtl/hold_queue_ptr.sv
// Wrapping storage pointer for the hold queue: counts 0..DEPTH-1 and
// returns to 0, so DEPTH need not be a power of two.
module hold_queue_ptr
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             advance,
    output logic [hold_ptr_width(DEPTH)-1:0] ptr
);
    localparam int            PW   = hold_ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_r;

    // Pointer register: reset/clear to 0, otherwise step with wrap at LAST.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= (ptr_r == LAST) ? '0 : ptr_r + PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;
endmodule

// File: rtl/hold_queue.sv
// Multi-entry pipeline hold queue: buffers up to DEPTH words while the
// downstream stage stalls and releases them in FIFO order.
// Optional zero-latency bypass when empty: define HOLD_QUEUE_BYPASS_EN.
module hold_queue
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    hold_queue_if.slave bus
);
    localparam int            CW         = hold_count_width(DEPTH);
    localparam int            PW         = hold_ptr_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic [PW-1:0]    head_s;
    logic [PW-1:0]    tail_s;

    logic             empty_s;
    logic             full_s;
    logic             ready_s;
    logic             accept_s;
    logic             bypass_s;
    logic             valid_s;
    logic             push_s;
    logic             drop_s;
    logic             head_adv_s;
    logic             tail_adv_s;
    logic [WIDTH-1:0] data_s;
    upd_e             upd_s;

    assign empty_s  = (count_r == '0);
    assign full_s   = (count_r == FULL_COUNT);
    // Backpressure depends only on stored state, never on stall.
    assign ready_s  = !full_s && !reset;
    assign accept_s = bus.input_valid && ready_s && !bus.flush;
    // Words offered while full are lost; a flush cycle ignores its input.
    assign drop_s   = bus.input_valid && full_s && !bus.flush;

`ifdef HOLD_QUEUE_BYPASS_EN
    // Stall is included so a stalled empty queue stores the word instead.
    assign bypass_s = empty_s && accept_s && !bus.stall;
`else
    assign bypass_s = 1'b0;
`endif

    assign valid_s = !reset && !bus.flush && !bus.stall && (!empty_s || bypass_s);
    assign push_s  = accept_s && !bypass_s;

    // Classify this cycle's state update (consume happens whenever valid_s).
    always_comb begin
        upd_s = UPD_IDLE;
        if (bypass_s) begin
            upd_s = UPD_BYPASS;
        end else if (push_s && valid_s) begin
            upd_s = UPD_BOTH;
        end else if (push_s) begin
            upd_s = UPD_PUSH;
        end else if (valid_s) begin
            upd_s = UPD_POP;
        end else begin
            upd_s = UPD_IDLE;
        end
    end

    // Pointer advance requests derived from the update class.
    always_comb begin
        head_adv_s = 1'b0;
        tail_adv_s = 1'b0;
        case (upd_s)
            UPD_BOTH: begin
                head_adv_s = 1'b1;
                tail_adv_s = 1'b1;
            end
            UPD_PUSH: tail_adv_s = 1'b1;
            UPD_POP:  head_adv_s = 1'b1;
            default: begin
                head_adv_s = 1'b0;
                tail_adv_s = 1'b0;
            end
        endcase
    end

    // Output word: head entry, the bypassed input, or zero when idle.
    always_comb begin
        data_s = '0;
        if (!valid_s) begin
            data_s = '0;
        end else if (!empty_s) begin
            data_s = mem_r[head_s];
        end else begin
            data_s = bus.data_in;
        end
    end

    // Occupancy and sticky overflow; flush empties but keeps overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (bus.flush) begin
            count_r <= '0;
        end else begin
            case (upd_s)
                UPD_PUSH: count_r <= count_r + CW'(1);
                UPD_POP:  count_r <= count_r - CW'(1);
                default:  count_r <= count_r;
            endcase
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Storage write at the tail; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_s] <= bus.data_in;
        end
    end

    hold_queue_ptr #(.DEPTH(DEPTH)) u_head (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.flush),
        .advance (head_adv_s),
        .ptr     (head_s)
    );

    hold_queue_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.flush),
        .advance (tail_adv_s),
        .ptr     (tail_s)
    );

    assign bus.ready_out = ready_s;
    assign bus.valid_out = valid_s;
    assign bus.data_out  = data_s;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_hold_queue.sv
// Directed bench for hold_queue: DEPTH=4 (table + bypass/flush/reset),
// DEPTH=3 (wrap-around against a small model), DEPTH=2 (overflow).
// Expectations follow HOLD_QUEUE_BYPASS_EN when it is defined.
module tb_hold_queue;
    import pipeline_pkg::*;

`ifdef HOLD_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hold_queue_if #(.WIDTH(8), .DEPTH(4)) q4_if ();
    hold_queue_if #(.WIDTH(8), .DEPTH(3)) q3_if ();
    hold_queue_if #(.WIDTH(8), .DEPTH(2)) q2_if ();

    hold_queue #(.WIDTH(8), .DEPTH(4)) u_q4 (.clk(clk), .reset(rst), .bus(q4_if));
    hold_queue #(.WIDTH(8), .DEPTH(3)) u_q3 (.clk(clk), .reset(rst), .bus(q3_if));
    hold_queue #(.WIDTH(8), .DEPTH(2)) u_q2 (.clk(clk), .reset(rst), .bus(q2_if));

    typedef struct {
        logic       rst;
        logic       stall;
        logic       flush;
        logic       iv;
        logic [7:0] din;
        logic       exp_valid;
        logic [7:0] exp_dout;
        logic       exp_ready;
        logic [2:0] exp_count;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Each drive task waits for the edge, applies inputs, then settles 1ns.
    task automatic d4(input logic iv, input logic [7:0] din, input logic st, input logic fl);
        @(posedge clk); #1;
        q4_if.input_valid = iv; q4_if.data_in = din; q4_if.stall = st; q4_if.flush = fl;
        #1;
    endtask

    task automatic d3(input logic iv, input logic [7:0] din, input logic st, input logic fl);
        @(posedge clk); #1;
        q3_if.input_valid = iv; q3_if.data_in = din; q3_if.stall = st; q3_if.flush = fl;
        #1;
    endtask

    task automatic d2(input logic iv, input logic [7:0] din, input logic st, input logic fl);
        @(posedge clk); #1;
        q2_if.input_valid = iv; q2_if.data_in = din; q2_if.stall = st; q2_if.flush = fl;
        #1;
    endtask

    task automatic c4(input string nm, input logic v, input logic [7:0] d,
                      input logic r, input int cnt, input logic ovf);
        chk({nm, "_valid"}, 32'(q4_if.valid_out), 32'(v));
        chk({nm, "_dout"},  32'(q4_if.data_out),  32'(d));
        chk({nm, "_ready"}, 32'(q4_if.ready_out), 32'(r));
        chk({nm, "_count"}, 32'(q4_if.count),     32'(cnt));
        chk({nm, "_ovf"},   32'(q4_if.overflow),  32'(ovf));
    endtask

    task automatic c2(input string nm, input logic v, input logic [7:0] d,
                      input logic r, input int cnt, input logic ovf);
        chk({nm, "_valid"}, 32'(q2_if.valid_out), 32'(v));
        chk({nm, "_dout"},  32'(q2_if.data_out),  32'(d));
        chk({nm, "_ready"}, 32'(q2_if.ready_out), 32'(r));
        chk({nm, "_count"}, 32'(q2_if.count),     32'(cnt));
        chk({nm, "_ovf"},   32'(q2_if.overflow),  32'(ovf));
    endtask

    initial begin
        int          mq [$];
        int          mc;
        logic        st;
        logic        e_ready;
        logic        e_byp;
        logic        e_valid;
        logic [7:0]  e_d;
        logic [7:0]  din;

        // Fill-then-drain table for DEPTH=4; all pushes are stalled so the
        // expectations hold with or without bypass.
        //              rst  stall flush iv   din    v     dout   rdy   cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 3'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 3'd2};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 3'd3};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd4};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 3'd4};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 3'd3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 3'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 3'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0};

        rst = 1'b1;
        q4_if.input_valid = 1'b0; q4_if.data_in = 8'h00; q4_if.stall = 1'b0; q4_if.flush = 1'b0;
        q3_if.input_valid = 1'b0; q3_if.data_in = 8'h00; q3_if.stall = 1'b0; q3_if.flush = 1'b0;
        q2_if.input_valid = 1'b0; q2_if.data_in = 8'h00; q2_if.stall = 1'b0; q2_if.flush = 1'b0;
        @(posedge clk); #1;

        // ---- table-driven fill and drain (DEPTH=4) ----
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            rst = tbl[i].rst;
            q4_if.input_valid = tbl[i].iv;  q4_if.data_in = tbl[i].din;
            q4_if.stall       = tbl[i].stall; q4_if.flush = tbl[i].flush;
            #1;
            c4($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_dout,
               tbl[i].exp_ready, int'(tbl[i].exp_count), 1'b0);
        end

        // ---- empty queue, not stalled: bypass or one-cycle latency ----
        d4(1'b1, 8'hA5, 1'b0, 1'b0);
        c4("byp0", BYP, BYP ? 8'hA5 : 8'h00, 1'b1, 0, 1'b0);
        d4(1'b0, 8'h00, 1'b0, 1'b0);
        c4("byp1", !BYP, BYP ? 8'h00 : 8'hA5, 1'b1, BYP ? 0 : 1, 1'b0);
        d4(1'b0, 8'h00, 1'b0, 1'b0);
        c4("byp2", 1'b0, 8'h00, 1'b1, 0, 1'b0);

        // ---- flush with three stored words ----
        d4(1'b1, 8'h11, 1'b1, 1'b0);
        d4(1'b1, 8'h12, 1'b1, 1'b0);
        d4(1'b1, 8'h13, 1'b1, 1'b0);
        d4(1'b1, 8'h99, 1'b0, 1'b1);
        c4("fl0", 1'b0, 8'h00, 1'b1, 3, 1'b0);
        d4(1'b0, 8'h00, 1'b0, 1'b0);
        c4("fl1", 1'b0, 8'h00, 1'b1, 0, 1'b0);
        d4(1'b1, 8'h21, 1'b1, 1'b0);
        c4("fl2", 1'b0, 8'h00, 1'b1, 0, 1'b0);
        d4(1'b0, 8'h00, 1'b0, 1'b0);
        c4("fl3", 1'b1, 8'h21, 1'b1, 1, 1'b0);
        d4(1'b0, 8'h00, 1'b0, 1'b0);
        c4("fl4", 1'b0, 8'h00, 1'b1, 0, 1'b0);

        // ---- reset with three stored words ----
        d4(1'b1, 8'h31, 1'b1, 1'b0);
        d4(1'b1, 8'h32, 1'b1, 1'b0);
        d4(1'b1, 8'h33, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        q4_if.input_valid = 1'b1; q4_if.data_in = 8'h44; q4_if.stall = 1'b0;
        #1;
        c4("rs0", 1'b0, 8'h00, 1'b0, 3, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        q4_if.input_valid = 1'b0;
        #1;
        c4("rs1", 1'b0, 8'h00, 1'b1, 0, 1'b0);

        // ---- wrap-around, DEPTH=3, checked against a small FIFO model ----
        mc = 0;
        for (int i = 0; i < 10; i++) begin
            st  = (i % 2 == 0);
            din = 8'h40 + 8'(i);
            d3(1'b1, din, st, 1'b0);
            e_ready = (mc < 3);
            e_byp   = BYP && (mc == 0) && !st && e_ready;
            e_valid = !st && (mc > 0 || e_byp);
            e_d     = !e_valid ? 8'h00 : (mc > 0 ? 8'(mq[0]) : din);
            chk($sformatf("wrap%0d_valid", i), 32'(q3_if.valid_out), 32'(e_valid));
            chk($sformatf("wrap%0d_dout", i),  32'(q3_if.data_out),  32'(e_d));
            chk($sformatf("wrap%0d_ready", i), 32'(q3_if.ready_out), 32'(e_ready));
            chk($sformatf("wrap%0d_count", i), 32'(q3_if.count),     32'(mc));
            if (e_valid && mc > 0) void'(mq.pop_front());
            if (e_ready && !e_byp) mq.push_back(int'(din));
            mc = mq.size();
        end
        for (int i = 0; i < 6 && mq.size() > 0; i++) begin
            d3(1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("wdrain%0d_valid", i), 32'(q3_if.valid_out), 32'd1);
            chk($sformatf("wdrain%0d_dout", i),  32'(q3_if.data_out),  32'(mq[0]));
            void'(mq.pop_front());
        end
        d3(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wdrain_end_valid", 32'(q3_if.valid_out), 32'd0);
        chk("wdrain_end_count", 32'(q3_if.count),     32'd0);

        // ---- overflow, DEPTH=2 ----
        d2(1'b1, 8'h06, 1'b1, 1'b0);
        c2("ov0", 1'b0, 8'h00, 1'b1, 0, 1'b0);
        d2(1'b1, 8'h08, 1'b1, 1'b0);
        c2("ov1", 1'b0, 8'h00, 1'b1, 1, 1'b0);
        d2(1'b1, 8'h07, 1'b1, 1'b0);
        c2("ov2", 1'b0, 8'h00, 1'b0, 2, 1'b0);
        d2(1'b0, 8'h00, 1'b0, 1'b0);
        c2("ov3", 1'b1, 8'h06, 1'b0, 2, 1'b1);
        d2(1'b0, 8'h00, 1'b0, 1'b0);
        c2("ov4", 1'b1, 8'h08, 1'b1, 1, 1'b1);
        d2(1'b0, 8'h00, 1'b0, 1'b0);
        c2("ov5", 1'b0, 8'h00, 1'b1, 0, 1'b1);
        d2(1'b1, 8'h55, 1'b0, 1'b1);
        c2("ov6", 1'b0, 8'h00, 1'b1, 0, 1'b1);
        d2(1'b0, 8'h00, 1'b0, 1'b0);
        c2("ov7", 1'b0, 8'h00, 1'b1, 0, 1'b1);

        // ---- reset while full and stalled clears overflow ----
        d2(1'b1, 8'h0A, 1'b1, 1'b0);
        d2(1'b1, 8'h0B, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        q2_if.input_valid = 1'b1; q2_if.data_in = 8'h0C; q2_if.stall = 1'b1;
        #1;
        c2("ovr0", 1'b0, 8'h00, 1'b0, 2, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        q2_if.input_valid = 1'b0; q2_if.stall = 1'b0;
        #1;
        c2("ovr1", 1'b0, 8'h00, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
